mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared types for the memory access unit: access-size and
//                FSM state encodings plus the size-code decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    // Code 2'b11 is folded onto a word access.
    function automatic size_e decode_size(input logic [1:0] code);
        case (code)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Data-memory request/response bus between the access unit
//                (master) and the memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] be;
    logic              ack;
    logic [XLEN-1:0]   rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane logic: word address, byte enables,
//                store-data replication and load lane select/extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   i_addr,
    input  size_e             i_size,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_word_addr,
    output logic [XLEN/8-1:0] o_be,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_load_data
);

    localparam int c_NB   = XLEN / 8;
    localparam int c_OFFW = $clog2(c_NB);
    localparam logic [c_NB-1:0] c_BE_B = c_NB'(1);
    localparam logic [c_NB-1:0] c_BE_H = c_NB'(3);
    localparam logic [c_NB-1:0] c_BE_W = c_NB'(15);

    logic [c_OFFW-1:0] w_off;
    logic [XLEN-1:0]   w_shifted;

    always_comb begin
        // Misaligned offsets are truncated to the natural alignment of the size.
        w_off = i_addr[c_OFFW-1:0];
        case (i_size)
            SZ_HALF: w_off[0]   = 1'b0;
            SZ_WORD: w_off[1:0] = 2'b00;
            default: ;
        endcase

        o_word_addr = {i_addr[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};

        case (i_size)
            SZ_BYTE: o_be = c_BE_B << w_off;
            SZ_HALF: o_be = c_BE_H << w_off;
            default: o_be = c_BE_W << w_off;
        endcase

        o_wdata = '0;
        for (int i = 0; i < c_NB; i++) begin
            case (i_size)
                SZ_BYTE: o_wdata[8*i +: 8] = i_wdata[7:0];
                SZ_HALF: o_wdata[8*i +: 8] = i_wdata[8*(i%2) +: 8];
                default: o_wdata[8*i +: 8] = i_wdata[8*(i%4) +: 8];
            endcase
        end

        w_shifted = i_rdata >> {w_off, 3'b000};
        case (i_size)
            SZ_BYTE: o_load_data = i_unsigned ? XLEN'(w_shifted[7:0])
                                              : XLEN'($signed(w_shifted[7:0]));
            SZ_HALF: o_load_data = i_unsigned ? XLEN'(w_shifted[15:0])
                                              : XLEN'($signed(w_shifted[15:0]));
            default: o_load_data = i_unsigned ? XLEN'(w_shifted[31:0])
                                              : XLEN'($signed(w_shifted[31:0]));
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage unit: accepts an EX bundle, performs one data
//                memory access with timeout, and emits a writeback bundle.
//                Optional macro MEM_ACCESS_MISALIGN_TRAP_EN adds a misalign
//                output and traps misaligned half/word accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    mem_access_unit_if.master dmem,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_reg,
    output logic              wb_reg_write,
    output logic              stall,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              err_timeout
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    state_e              r_state, w_state_nxt;
    logic [XLEN-1:0]     r_alu_out, r_wdata;
    logic [REG_AW-1:0]   r_wreg;
    logic                r_reg_write, r_load, r_store, r_unsigned, r_timeout;
    size_e               r_size;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic [XLEN-1:0]     r_wb_data;
    logic [REG_AW-1:0]   r_wb_reg;
    logic                r_wb_reg_write;

    logic                w_accept, w_in_is_mem, w_in_misalign, w_in_wait, w_timeout_hit;
    logic                w_wb_load, w_wb_we_nxt;
    logic [XLEN-1:0]     w_wb_data_nxt;
    logic [REG_AW-1:0]   w_wb_reg_nxt;
    logic [XLEN-1:0]     w_word_addr, w_st_wdata, w_load_data;
    logic [XLEN/8-1:0]   w_be;

    assign w_in_is_mem = ex_mem_read | ex_mem_write;
    assign w_accept    = (r_state == IDLE) & in_valid;
    assign w_in_wait   = (r_state == WAIT);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic r_misalign;

    always_comb begin
        w_in_misalign = 1'b0;
        if (w_in_is_mem) begin
            case (decode_size(ex_size))
                SZ_HALF: w_in_misalign = ex_alu_out[0];
                SZ_WORD: w_in_misalign = |ex_alu_out[1:0];
                default: ;
            endcase
        end
    end

    assign misalign = (r_state == DONE) & r_misalign;

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (w_accept)
            r_misalign <= w_in_misalign;
    end
`else
    assign w_in_misalign = 1'b0;
`endif

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .i_addr      (r_alu_out),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .i_rdata     (dmem.rdata),
        .o_word_addr (w_word_addr),
        .o_be        (w_be),
        .o_wdata     (w_st_wdata),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_wb_load     = 1'b0;
        w_wb_data_nxt = r_alu_out;
        w_wb_reg_nxt  = r_wreg;
        w_wb_we_nxt   = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_in_is_mem && !w_in_misalign) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt   = DONE;
                        w_wb_load     = 1'b1;
                        w_wb_data_nxt = ex_alu_out;
                        w_wb_reg_nxt  = ex_wreg;
                        w_wb_we_nxt   = ex_reg_write & ~w_in_misalign;
                    end
                end
            end
            WAIT: begin
                if (dmem.ack) begin
                    w_state_nxt   = DONE;
                    w_wb_load     = 1'b1;
                    w_wb_data_nxt = r_load ? w_load_data : r_alu_out;
                    w_wb_we_nxt   = r_reg_write;
                end else if (r_wait_cnt == c_CNT_LAST) begin
                    // Abandon the request; writeback is emitted without a register write.
                    w_state_nxt   = DONE;
                    w_wb_load     = 1'b1;
                    w_timeout_hit = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_alu_out      <= '0;
            r_wdata        <= '0;
            r_wreg         <= '0;
            r_reg_write    <= 1'b0;
            r_load         <= 1'b0;
            r_store        <= 1'b0;
            r_size         <= SZ_BYTE;
            r_unsigned     <= 1'b0;
            r_timeout      <= 1'b0;
            r_wait_cnt     <= '0;
            r_wb_data      <= '0;
            r_wb_reg       <= '0;
            r_wb_reg_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_alu_out   <= ex_alu_out;
                r_wdata     <= ex_wdata;
                r_wreg      <= ex_wreg;
                r_reg_write <= ex_reg_write & ~ex_mem_write;
                r_load      <= ex_mem_read & ~ex_mem_write;
                r_store     <= ex_mem_write;
                r_size      <= decode_size(ex_size);
                r_unsigned  <= ex_unsigned;
                r_timeout   <= 1'b0;
            end
            if (w_timeout_hit)
                r_timeout <= 1'b1;
            if (w_in_wait)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (w_wb_load) begin
                r_wb_data      <= w_wb_data_nxt;
                r_wb_reg       <= w_wb_reg_nxt;
                r_wb_reg_write <= w_wb_we_nxt;
            end
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign stall        = ~in_ready;
    assign wb_valid     = (r_state == DONE);
    assign wb_data      = r_wb_data;
    assign wb_reg       = r_wb_reg;
    assign wb_reg_write = r_wb_reg_write;
    assign err_timeout  = (r_state == DONE) & r_timeout;

    // Bus fields are zeroed outside WAIT so the idle bus is quiet.
    assign dmem.req   = w_in_wait;
    assign dmem.we    = w_in_wait & r_store;
    assign dmem.addr  = w_in_wait ? w_word_addr : '0;
    assign dmem.wdata = w_in_wait ? w_st_wdata  : '0;
    assign dmem.be    = w_in_wait ? w_be        : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a writeback
//                scoreboard; honours MEM_ACCESS_MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int XLEN        = 32;
    localparam int REG_AW      = 5;
    localparam int TIMEOUT_CYC = 15;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] rg;
        logic              we;
    } wb_t;

    // Load table: address, size code, unsigned, read word, expected result,
    // expected word address, expected byte enables, ack delay in cycles.
    localparam logic [31:0] L_ADDR  [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h201, 32'h104};
    localparam logic [1:0]  L_SZ    [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
    localparam logic        L_UNS   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [31:0] L_RDATA [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234,
                                            32'h8001F234, 32'h00007F00, 32'hDEADBEEF};
    localparam logic [31:0] L_EXP   [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                            32'h0000F234, 32'h0000007F, 32'hDEADBEEF};
    localparam logic [31:0] L_WADDR [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h104};
    localparam logic [3:0]  L_BE    [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
    localparam int          L_DLY   [6] = '{3, 1, 1, 2, 1, 4};

    // Store table: address, store data, size code, mem_read also set,
    // expected word address, byte enables, replicated data.
    localparam logic [31:0] S_ADDR  [4] = '{32'h102, 32'h101, 32'h108, 32'h10F};
    localparam logic [31:0] S_WD    [4] = '{32'h0000ABCD, 32'hFFFFFF5A, 32'h12345678, 32'h000000C3};
    localparam logic [1:0]  S_SZ    [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    localparam logic        S_RD    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] S_WADDR [4] = '{32'h100, 32'h100, 32'h108, 32'h10C};
    localparam logic [3:0]  S_BE    [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    localparam logic [31:0] S_EXPWD [4] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h12345678, 32'hC3C3C3C3};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   ex_alu_out = '0;
    logic [XLEN-1:0]   ex_wdata = '0;
    logic [REG_AW-1:0] ex_wreg = '0;
    logic              ex_reg_write = 1'b0;
    logic              ex_mem_read = 1'b0;
    logic              ex_mem_write = 1'b0;
    logic [1:0]        ex_size = 2'b00;
    logic              ex_unsigned = 1'b0;
    logic              wb_valid;
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] wb_reg;
    logic              wb_reg_write;
    logic              stall;
    logic              err_timeout;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic              misalign;
`endif

    int  n_vec = 0;
    int  n_err = 0;
    wb_t sb[$];

    mem_access_unit_if #(.XLEN(XLEN)) dmem ();

    mem_access_unit #(
        .XLEN        (XLEN),
        .REG_AW      (REG_AW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ex_alu_out   (ex_alu_out),
        .ex_wdata     (ex_wdata),
        .ex_wreg      (ex_wreg),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .dmem         (dmem),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_reg_write (wb_reg_write),
        .stall        (stall),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        .misalign     (misalign),
`endif
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rg,
                         input logic rw, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns);
        ex_alu_out   = alu;
        ex_wdata     = wd;
        ex_wreg      = rg;
        ex_reg_write = rw;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_size      = sz;
        ex_unsigned  = uns;
        in_valid     = 1'b1;
    endtask

    task automatic test_reset();
        wb_t exp;
        rst = 1'b1;
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        step();
        step();
        n_vec++;
        if ({in_ready, stall} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_ready: got ready/stall=%b%b want 10", in_ready, stall);
        end
        n_vec++;
        if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.be} !== '0) begin
            n_err++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wd=%h be=%b want all 0",
                     dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.be);
        end
        exp = '0;
        n_vec++;
        if ({wb_valid, wb_data, wb_reg, wb_reg_write, err_timeout} !== {1'b0, exp, 1'b0}) begin
            n_err++;
            $display("FAIL reset_wb: got v=%b d=%h r=%0d w=%b to=%b want all 0",
                     wb_valid, wb_data, wb_reg, wb_reg_write, err_timeout);
        end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        n_vec++;
        if (misalign !== 1'b0) begin
            n_err++;
            $display("FAIL reset_misalign: got %b want 0", misalign);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_nonmem();
        wb_t exp;
        drive(32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        sb.push_back('{data: 32'h1234, rg: 5'd7, we: 1'b1});
        step();
        in_valid = 1'b0;
        exp = sb.pop_front();
        n_vec++;
        if ({wb_valid, wb_data, wb_reg, wb_reg_write, dmem.req, stall} !== {1'b1, exp, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL nonmem_wb: got v=%b d=%h r=%0d w=%b req=%b stall=%b want v=1 d=%h r=%0d w=%b req=0 stall=1",
                     wb_valid, wb_data, wb_reg, wb_reg_write, dmem.req, stall, exp.data, exp.rg, exp.we);
        end
        step();
        n_vec++;
        if ({wb_valid, in_ready, wb_data, wb_reg} !== {1'b0, 1'b1, 32'h1234, 5'd7}) begin
            n_err++;
            $display("FAIL nonmem_hold: got v=%b rdy=%b d=%h r=%0d want v=0 rdy=1 d=00001234 r=7",
                     wb_valid, in_ready, wb_data, wb_reg);
        end
    endtask

    task automatic test_load();
        wb_t exp;
        for (int i = 0; i < 6; i++) begin
            drive(L_ADDR[i], 32'hCAFE0000, 5'(i + 1), 1'b1, 1'b1, 1'b0, L_SZ[i], L_UNS[i]);
            sb.push_back('{data: L_EXP[i], rg: 5'(i + 1), we: 1'b1});
            step();
            in_valid = 1'b0;
            for (int c = 1; c <= L_DLY[i]; c++) begin
                n_vec++;
                if ({dmem.req, dmem.we, dmem.addr, dmem.be, wb_valid} !== {1'b1, 1'b0, L_WADDR[i], L_BE[i], 1'b0}) begin
                    n_err++;
                    $display("FAIL load[%0d] cyc%0d bus: got req=%b we=%b addr=%h be=%b v=%b want req=1 we=0 addr=%h be=%b v=0",
                             i, c, dmem.req, dmem.we, dmem.addr, dmem.be, wb_valid, L_WADDR[i], L_BE[i]);
                end
                if (c == L_DLY[i]) begin
                    dmem.ack   = 1'b1;
                    dmem.rdata = L_RDATA[i];
                end
                step();
            end
            dmem.ack   = 1'b0;
            dmem.rdata = 32'h0BAD0BAD;
            exp = sb.pop_front();
            n_vec++;
            if ({wb_valid, wb_data, wb_reg, wb_reg_write, dmem.req} !== {1'b1, exp, 1'b0}) begin
                n_err++;
                $display("FAIL load[%0d] wb: got v=%b d=%h r=%0d w=%b req=%b want v=1 d=%h r=%0d w=%b req=0",
                         i, wb_valid, wb_data, wb_reg, wb_reg_write, dmem.req, exp.data, exp.rg, exp.we);
            end
            step();
        end
    endtask

    task automatic test_store();
        wb_t exp;
        for (int i = 0; i < 4; i++) begin
            drive(S_ADDR[i], S_WD[i], 5'(i + 20), 1'b1, S_RD[i], 1'b1, S_SZ[i], 1'b0);
            sb.push_back('{data: S_ADDR[i], rg: 5'(i + 20), we: 1'b0});
            step();
            in_valid = 1'b0;
            n_vec++;
            if ({in_ready, dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata} !==
                {1'b0, 1'b1, 1'b1, S_WADDR[i], S_BE[i], S_EXPWD[i]}) begin
                n_err++;
                $display("FAIL store[%0d] bus: got rdy=%b req=%b we=%b addr=%h be=%b wd=%h want rdy=0 req=1 we=1 addr=%h be=%b wd=%h",
                         i, in_ready, dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata,
                         S_WADDR[i], S_BE[i], S_EXPWD[i]);
            end
            dmem.ack   = 1'b1;
            dmem.rdata = 32'h55AA55AA;
            step();
            dmem.ack = 1'b0;
            exp = sb.pop_front();
            n_vec++;
            if ({wb_valid, wb_data, wb_reg, wb_reg_write} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL store[%0d] wb: got v=%b d=%h r=%0d w=%b want v=1 d=%h r=%0d w=%b",
                         i, wb_valid, wb_data, wb_reg, wb_reg_write, exp.data, exp.rg, exp.we);
            end
            step();
        end
    endtask

    task automatic test_ack_ignored();
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if ({wb_valid, in_ready, dmem.req} !== 3'b010) begin
                n_err++;
                $display("FAIL ack_idle cyc%0d: got v=%b rdy=%b req=%b want v=0 rdy=1 req=0",
                         c, wb_valid, in_ready, dmem.req);
            end
        end
        dmem.ack = 1'b0;
    endtask

    task automatic test_timeout();
        wb_t exp;
        int  reqc = 0;
        drive(32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        sb.push_back('{data: 32'h10, rg: 5'd9, we: 1'b0});
        step();
        in_valid = 1'b0;
        while (dmem.req === 1'b1 && reqc < 40) begin
            reqc++;
            step();
        end
        n_vec++;
        if (reqc != TIMEOUT_CYC) begin
            n_err++;
            $display("FAIL timeout_len: got req held %0d cycles want %0d", reqc, TIMEOUT_CYC);
        end
        n_vec++;
        if ({err_timeout, wb_valid, dmem.req} !== 3'b110) begin
            n_err++;
            $display("FAIL timeout_pulse: got to=%b v=%b req=%b want to=1 v=1 req=0",
                     err_timeout, wb_valid, dmem.req);
        end
        exp = sb.pop_front();
        n_vec++;
        if ({wb_data, wb_reg, wb_reg_write} !== exp) begin
            n_err++;
            $display("FAIL timeout_wb: got d=%h r=%0d w=%b want d=%h r=%0d w=%b",
                     wb_data, wb_reg, wb_reg_write, exp.data, exp.rg, exp.we);
        end
        step();
        n_vec++;
        if ({err_timeout, wb_valid, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL timeout_after: got to=%b v=%b rdy=%b want to=0 v=0 rdy=1",
                     err_timeout, wb_valid, in_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        int bad = 0;
        drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        n_vec++;
        if (dmem.req !== 1'b1) begin
            n_err++;
            $display("FAIL rstwait_pre: got req=%b want 1", dmem.req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({dmem.req, in_ready, wb_valid, err_timeout} !== 4'b0100) begin
            n_err++;
            $display("FAIL rstwait_post: got req=%b rdy=%b v=%b to=%b want req=0 rdy=1 v=0 to=0",
                     dmem.req, in_ready, wb_valid, err_timeout);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            if (wb_valid !== 1'b0 || err_timeout !== 1'b0 || dmem.req !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rstwait_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_misalign();
        wb_t exp;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        drive(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        sb.push_back('{data: 32'h102, rg: 5'd6, we: 1'b0});
        step();
        in_valid = 1'b0;
        n_vec++;
        if ({misalign, wb_valid, dmem.req} !== 3'b110) begin
            n_err++;
            $display("FAIL misalign_trap: got mis=%b v=%b req=%b want mis=1 v=1 req=0",
                     misalign, wb_valid, dmem.req);
        end
        exp = sb.pop_front();
        n_vec++;
        if ({wb_data, wb_reg, wb_reg_write} !== exp) begin
            n_err++;
            $display("FAIL misalign_wb: got d=%h r=%0d w=%b want d=%h r=%0d w=%b",
                     wb_data, wb_reg, wb_reg_write, exp.data, exp.rg, exp.we);
        end
        step();
        n_vec++;
        if ({misalign, wb_valid, dmem.req} !== 3'b000) begin
            n_err++;
            $display("FAIL misalign_after: got mis=%b v=%b req=%b want 000", misalign, wb_valid, dmem.req);
        end
`else
        // lw at 0x102 truncates to 0x100; lh at 0x103 truncates to lane 2.
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
                sb.push_back('{data: 32'h11223344, rg: 5'd6, we: 1'b1});
            end else begin
                drive(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
                sb.push_back('{data: 32'h00007FFE, rg: 5'd8, we: 1'b1});
            end
            step();
            in_valid = 1'b0;
            n_vec++;
            if ({dmem.req, dmem.addr, dmem.be} !== {1'b1, 32'h100, (i == 0) ? 4'b1111 : 4'b1100}) begin
                n_err++;
                $display("FAIL trunc[%0d] bus: got req=%b addr=%h be=%b want req=1 addr=00000100 be=%b",
                         i, dmem.req, dmem.addr, dmem.be, (i == 0) ? 4'b1111 : 4'b1100);
            end
            dmem.ack   = 1'b1;
            dmem.rdata = (i == 0) ? 32'h11223344 : 32'h7FFE0000;
            step();
            dmem.ack = 1'b0;
            exp = sb.pop_front();
            n_vec++;
            if ({wb_valid, wb_data, wb_reg, wb_reg_write} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL trunc[%0d] wb: got v=%b d=%h r=%0d w=%b want v=1 d=%h r=%0d w=%b",
                         i, wb_valid, wb_data, wb_reg, wb_reg_write, exp.data, exp.rg, exp.we);
            end
            step();
        end
`endif
    endtask

    task automatic test_back_to_back();
        wb_t exp;
        // in_valid stays high across DONE to confirm nothing is accepted there.
        for (int k = 0; k < 4; k++) begin
            drive(32'h100 * k + 32'h5, 32'h0, 5'(k + 10), k[0], 1'b0, 1'b0, 2'b10, 1'b0);
            sb.push_back('{data: 32'h100 * k + 32'h5, rg: 5'(k + 10), we: k[0]});
            step();
            exp = sb.pop_front();
            n_vec++;
            if ({wb_valid, stall, wb_data, wb_reg, wb_reg_write} !== {2'b11, exp}) begin
                n_err++;
                $display("FAIL b2b[%0d] wb: got v=%b stall=%b d=%h r=%0d w=%b want v=1 stall=1 d=%h r=%0d w=%b",
                         k, wb_valid, stall, wb_data, wb_reg, wb_reg_write, exp.data, exp.rg, exp.we);
            end
            step();
            n_vec++;
            if ({wb_valid, in_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL b2b[%0d] idle: got v=%b rdy=%b want v=0 rdy=1", k, wb_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_ack_ignored();
        test_timeout();
        test_reset_in_wait();
        test_misalign();
        test_back_to_back();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
